piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in/serial-out stage that feeds the serial pattern detectors, including the 101 detector, one bit per clock. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first on a registered serial line. Supports back-to-back words with no idle gap. Drives 0 on the line when idle, so idle periods never create spurious `1` bits downstream.

## Interface
Parameters:
- WIDTH, default 8, word width in bits; legal range ≥ 2.

Ports:
- clk  input  1  rising-edge clock; all state is in this single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to serialize; sampled only on handshake.
- ser_out  output  1  serial bit; connects to the detector's `x` input.
- ser_valid  output  1  ser_out carries a payload or parity bit this cycle.
- busy  output  1  a word is in flight (state ≠ IDLE).

## Operation
- State type `ser_state_e`: IDLE, SHIFT, and PARITY (PARITY is present only with the macro).
- Handshake: a word is accepted at a rising edge where `in_valid && in_ready`. `in_data` is loaded into the WIDTH-bit shift register, and the bit counter is loaded with WIDTH-1.
- in_ready is combinational from state:
  - 1 in IDLE.
  - 1 in the final bit cycle of a word: SHIFT with count == 0 without parity, or PARITY with parity.
  - 0 otherwise.
- in_ready never depends on in_valid.
- IDLE:
  - On handshake, go to SHIFT.
  - Otherwise stay in IDLE with ser_out = 0 and ser_valid = 0.
- SHIFT:
  - ser_out = shift_reg[WIDTH-1] and ser_valid = 1.
  - Each cycle, shift left by one (0 fills from the LSB) and decrement the count.
  - At count == 0 without parity: on handshake, reload and stay in SHIFT; otherwise go to IDLE.
  - At count == 0 with parity: go to PARITY.
- PARITY (macro only):
  - ser_out = even-parity bit (XOR of the accepted word, captured at load) and ser_valid = 1.
  - On handshake, reload and go to SHIFT; otherwise go to IDLE.
- in_valid may deassert without a handshake. in_data is don't-care when no handshake occurs.
- busy = (state != IDLE).

## Timing
- Reset (asynchronous assert) clears state and forces:
  - state = IDLE
  - shift_reg = 0, count = 0
  - ser_out = 0, ser_valid = 0, busy = 0
  - in_ready = 1 (IDLE)
- Reset release is synchronous to clk.
- Reset mid-word aborts the word: the remaining bits are discarded and nothing resumes.
- Latency: for a word accepted at edge N, the MSB appears on ser_out in the cycle after edge N. The LSB appears WIDTH-1 cycles later.
- Frame period:
  - WIDTH cycles without parity, WIDTH+1 with parity.
  - Sustained throughput is one word per frame period when in_valid is held high.
- Outputs are driven from registered state and the shift register. ser_out and ser_valid have no combinational path from inputs.
- Simultaneous last bit and new handshake: the last bit of the old word is output this cycle, and the new MSB is output next cycle, with no gap.

## Configuration
- `SERIALIZER_PARITY_EN` defined:
  - Adds the PARITY state and the 1-bit parity register.
  - One even-parity bit is appended after each word's LSB.
  - Frame is WIDTH+1 bits.
- `SERIALIZER_PARITY_EN` not defined:
  - No PARITY state and no parity register.
  - Frame is exactly WIDTH bits.

## Structure
- Package `serializer_pkg` holds:
  - `ser_state_e`, a 2-bit enum {IDLE, SHIFT, PARITY}. The encoding is fixed even when PARITY is unused.
  - Function `even_parity`.
- Flat module with no sub-modules. One `always_ff` block for state, shift register, counter and parity. One `always_comb` block for next-state and in_ready.
- Counter width is `$clog2(WIDTH)`.

## Test plan
All scenarios use WIDTH = 8.
- Reset during SHIFT after 3 bits of 0xFF: ser_out = 0, ser_valid = 0 and in_ready = 1 immediately at assertion. After release, ser_out stays 0 until a new word is accepted.
- Single word 0xA5, no macro: starting the cycle after accept, ser_out = 1,0,1,0,0,1,0,1 with ser_valid = 1 for 8 cycles, then returns to 0/0. A downstream 101 detector pulses y twice.
- Back-to-back 0xFF then 0x00 with in_valid held high: the handshake occurs on bit 7 of 0xFF, and the output is 16 contiguous valid bits (8 ones, then 8 zeros) with no gap.
- Macro defined, word 0xA5: 9 valid bits, with parity bit 0. Word 0x01: parity bit 1. in_ready is high only in the PARITY cycle.
- in_valid pulsed while in_ready = 0 (mid-word): the word is ignored, and the current frame is unchanged.
- in_valid = 0 for 20 cycles after reset: busy = 0, ser_valid = 0 and ser_out = 0 throughout.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Optional feature macro: SERIALIZER_PARITY_EN (appends an even-parity bit
// after each word). The state encoding below does not change with the macro.
package serializer_pkg;

  // Fixed 2-bit state codes. PARITY keeps its code even when it is unused.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SHIFT  = 2'b01;
  localparam logic [1:0] ST_PARITY = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY
  } ser_state_e;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PARITY_MAX_WIDTH = 64;

  // Even parity: 1 when the word holds an odd number of ones, so that the
  // word plus this bit always carries an even count.
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Handshake and serial-line bundle for piso_serializer.
// Optional feature macro: SERIALIZER_PARITY_EN (no effect on this file).
// master = upstream word source / downstream observer, slave = serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ser_out;
  logic             ser_valid;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  ser_out,
    input  ser_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output ser_out,
    output ser_valid
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words on a valid/ready
// handshake and shifts them out MSB-first, one bit per clock, with no idle
// gap between back-to-back words. The line is held at 0 while idle.
// Optional feature macro: SERIALIZER_PARITY_EN appends one even-parity bit
// after each word's LSB (frame becomes WIDTH+1 bits).
//
// state  | meaning
// IDLE   | no word in flight, line driven 0, ready for a word
// SHIFT  | payload bits on the line, MSB first
// PARITY | parity bit on the line (SERIALIZER_PARITY_EN only)
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  piso_serializer_if.slave   bus,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_e       r_state;
  ser_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_count;
  logic             w_ready;
  logic             w_load;
`ifdef SERIALIZER_PARITY_EN
  logic             r_parity;
`endif

  // Next-state and ready decode; ready depends only on state, never on valid.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
      end
      SHIFT: begin
        if (r_count == '0) begin
`ifdef SERIALIZER_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_ready = 1'b1;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        w_ready = 1'b1;
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_load = bus.in_valid && w_ready;
    // Every ready cycle ends a frame (or is idle): either start a new word
    // immediately or fall back to IDLE.
    if (w_ready) begin
      w_state_nxt = w_load ? SHIFT : IDLE;
    end
  end

  // State, shift register, bit counter and captured parity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_count  <= '0;
`ifdef SERIALIZER_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_shift  <= bus.in_data;
        r_count  <= CNT_LAST;
`ifdef SERIALIZER_PARITY_EN
        r_parity <= even_parity(PARITY_MAX_WIDTH'(bus.in_data));
`endif
      end else if (r_state == SHIFT) begin
        // Zero fill keeps the register clean once the word has drained.
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        if (r_count != '0) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign busy         = (r_state != IDLE);

`ifdef SERIALIZER_PARITY_EN
  assign bus.ser_valid = (r_state == SHIFT) || (r_state == PARITY);
  assign bus.ser_out   = (r_state == SHIFT)  ? r_shift[WIDTH-1] :
                         (r_state == PARITY) ? r_parity : 1'b0;
`else
  assign bus.ser_valid = (r_state == SHIFT);
  assign bus.ser_out   = (r_state == SHIFT) && r_shift[WIDTH-1];
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (WIDTH = 8). Build with or without
// SERIALIZER_PARITY_EN; expected frames follow the macro.
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = WIDTH;
  localparam bit PAR   = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic busy;

  piso_serializer_if #(.WIDTH(WIDTH)) bus ();

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  int   run_len = 0;
  int   max_run = 0;
  int   det_count = 0;
  logic [2:0] hist = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a valid bit.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check("busy_vs_valid", {31'd0, busy}, {31'd0, bus.ser_valid});
      if (bus.ser_valid === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        hist = {hist[1:0], bus.ser_out};
        if (hist == 3'b101) det_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit: got %0b expected no valid bit at %0t", bus.ser_out, $time);
        end else begin
          check("ser_bit", {31'd0, bus.ser_out}, {31'd0, exp_q.pop_front()});
        end
      end else begin
        run_len = 0;
        check("idle_line", {31'd0, bus.ser_out}, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge where the MSB is on the line.
  task automatic send(input logic [WIDTH-1:0] d, input logic par);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b expected 1 within 200 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
    if (PAR) exp_q.push_back(par);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset_n      = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_ser_out",   {31'd0, bus.ser_out},   32'd0);
    check("rst_ser_valid", {31'd0, bus.ser_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_busy",      {31'd0, busy},          32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset: line quiet for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy",      {31'd0, busy},          32'd0);
      check("idle_ser_valid", {31'd0, bus.ser_valid}, 32'd0);
      check("idle_ser_out",   {31'd0, bus.ser_out},   32'd0);
      check("idle_in_ready",  {31'd0, bus.in_ready},  32'd1);
    end

    // 0xA5: 1,0,1,0,0,1,0,1 (+ parity 0); ready only in the last frame cycle.
    hist      = 3'b000;
    det_count = 0;
    send(8'hA5, 1'b0);
    for (int k = 1; k <= FRAME; k++) begin
      check("ready_in_frame", {31'd0, bus.in_ready}, (k == FRAME) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("after_frame_ready", {31'd0, bus.in_ready},  32'd1);
    check("after_frame_valid", {31'd0, bus.ser_valid}, 32'd0);
    drain();
    check("det_101_count", det_count, 32'd2);

    // 0x01: parity bit 1 when the macro is on.
    send(8'h01, 1'b1);
    drain();

    // Back-to-back 0xFF then 0x00 with in_valid held: one unbroken run.
    max_run = 0;
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    drain();
    check("b2b_contiguous_run", max_run, 2 * FRAME);

    // Valid pulsed mid-word while not ready: must be ignored.
    send(8'h3C, 1'b0);
    @(negedge clk);
    check("midword_ready_low", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    drain();
    check("ignored_word_idle", {31'd0, busy}, 32'd0);

    // Reset after 3 bits of 0xFF aborts the word.
    send(8'hFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ser_out",   {31'd0, bus.ser_out},   32'd0);
    check("midrst_ser_valid", {31'd0, bus.ser_valid}, 32'd0);
    check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("midrst_busy",      {31'd0, busy},          32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_ser_out",   {31'd0, bus.ser_out},   32'd0);
      check("post_rst_ser_valid", {31'd0, bus.ser_valid}, 32'd0);
    end

    // Recovery: a fresh word serializes normally.
    send(8'h81, 1'b0);
    drain();
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
